// File: rtl/tiny_riscv_prog_ctrl.sv
// Program controller for the tiny RISC-V core: owns the 16x8 instruction memory,
// loads it from host bytes and sequences the core through run, single-step and halt.
module tiny_riscv_prog_ctrl #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  host_valid,
  input  logic [DATA_WIDTH-1:0] host_data,
  output logic                  host_ready,
  output logic                  core_start,
  input  logic                  core_fetch_req,
  input  logic [ADDR_WIDTH-1:0] core_fetch_addr,
  output logic [DATA_WIDTH-1:0] core_fetch_data,
  output logic                  core_fetch_valid,
  input  logic                  core_retire,
  input  logic                  core_halt,
  output logic [2:0]            status_state,
  output logic [7:0]            retire_count,
  output logic                  cmd_err
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  localparam logic [DATA_WIDTH-1:0] CMD_NOP  = DATA_WIDTH'(8'h00);
  localparam logic [DATA_WIDTH-1:0] CMD_RUN  = DATA_WIDTH'(8'h80);
  localparam logic [DATA_WIDTH-1:0] CMD_STEP = DATA_WIDTH'(8'h81);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    RUN    = 3'd2,
    STEP   = 3'd3,
    HALTED = 3'd4
  } state_t;

  state_t                  state;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic [ADDR_WIDTH-1:0]   load_addr;
  logic [ADDR_WIDTH-1:0]   load_last;
  logic                    token;
  logic                    xfer;
  logic                    grant;
  logic                    core_active;

  assign host_ready   = (state != STEP);
  assign status_state = state;
  assign xfer         = host_valid & host_ready;
  assign core_active  = (state == RUN) || (state == STEP);
  assign grant        = core_fetch_req & ((state == RUN) | ((state == STEP) & token));

  // NOTE: the memory sits on the async reset because it must read back as zero
  // after every reset; that rules out a RAM macro but the array is only 16 bytes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      load_addr        <= '0;
      load_last        <= '0;
      token            <= 1'b0;
      core_start       <= 1'b0;
      core_fetch_data  <= '0;
      core_fetch_valid <= 1'b0;
      retire_count     <= '0;
      cmd_err          <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      core_start       <= 1'b0;
      core_fetch_valid <= grant;
      if (grant) core_fetch_data <= mem[core_fetch_addr];
      if (grant && state == STEP) token <= 1'b0;
      if (core_active && core_retire) retire_count <= retire_count + 8'd1;

      unique case (state)
        IDLE, HALTED: begin
          if (xfer) begin
            if (host_data == CMD_RUN || host_data == CMD_STEP) begin
              state        <= (host_data == CMD_STEP) ? STEP : RUN;
              token        <= (host_data == CMD_STEP);
              core_start   <= 1'b1;
              retire_count <= '0;
            end else if (host_data == CMD_NOP) begin
              state <= IDLE;
            end else if (state == IDLE && host_data[DATA_WIDTH-1:4] == 4'h4) begin
              state     <= LOAD;
              load_addr <= '0;
              load_last <= host_data[ADDR_WIDTH-1:0];
            end else if (state == IDLE) begin
              cmd_err <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (xfer) begin
            mem[load_addr] <= host_data;
            load_addr      <= load_addr + 1'b1;
            if (load_addr == load_last) state <= IDLE;
          end
        end
        RUN: begin
          // Halt wins over a host stop arriving in the same cycle.
          if (core_halt) state <= HALTED;
          else if (xfer && host_data == CMD_NOP) state <= IDLE;
        end
        STEP: begin
          if (core_halt) state <= HALTED;
          else if (core_retire) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tiny_riscv_prog_ctrl.sv
// Directed bench for tiny_riscv_prog_ctrl: a vector table for load/run/step/halt
// plus hand sequences for reset mid-load and retire counter wrap.
module tb_tiny_riscv_prog_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       host_valid;
  logic [7:0] host_data;
  logic       host_ready;
  logic       core_start;
  logic       core_fetch_req;
  logic [3:0] core_fetch_addr;
  logic [7:0] core_fetch_data;
  logic       core_fetch_valid;
  logic       core_retire;
  logic       core_halt;
  logic [2:0] status_state;
  logic [7:0] retire_count;
  logic       cmd_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  tiny_riscv_prog_ctrl #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .host_valid       (host_valid),
    .host_data        (host_data),
    .host_ready       (host_ready),
    .core_start       (core_start),
    .core_fetch_req   (core_fetch_req),
    .core_fetch_addr  (core_fetch_addr),
    .core_fetch_data  (core_fetch_data),
    .core_fetch_valid (core_fetch_valid),
    .core_retire      (core_retire),
    .core_halt        (core_halt),
    .status_state     (status_state),
    .retire_count     (retire_count),
    .cmd_err          (cmd_err)
  );

  typedef struct {
    logic       hv;
    logic [7:0] hd;
    logic       req;
    logic [3:0] addr;
    logic       ret;
    logic       hlt;
    logic [2:0] st;
    logic       rdy;
    logic       start;
    logic       fv;
    logic [7:0] fd;
    logic [7:0] cnt;
    logic       err;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic hv, input logic [7:0] hd, input logic req,
                       input logic [3:0] addr, input logic ret, input logic hlt);
    host_valid      = hv;
    host_data       = hd;
    core_fetch_req  = req;
    core_fetch_addr = addr;
    core_retire     = ret;
    core_halt       = hlt;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    drive(1'b0, 8'h00, 1'b0, 4'h0, 1'b0, 1'b0);
  endtask

  initial begin
    //        hv    hd     req   addr  ret   hlt    st    rdy   start fv    fd     cnt    err
    vecs[0]  = '{1'b1, 8'h42, 1'b0, 4'h0, 1'b0, 1'b0, 3'd1, 1'b1, 1'b0, 1'b0, 8'h00, 8'd0, 1'b0};
    vecs[1]  = '{1'b1, 8'h11, 1'b0, 4'h0, 1'b0, 1'b0, 3'd1, 1'b1, 1'b0, 1'b0, 8'h00, 8'd0, 1'b0};
    vecs[2]  = '{1'b1, 8'h22, 1'b0, 4'h0, 1'b0, 1'b0, 3'd1, 1'b1, 1'b0, 1'b0, 8'h00, 8'd0, 1'b0};
    vecs[3]  = '{1'b1, 8'h33, 1'b0, 4'h0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 8'h00, 8'd0, 1'b0};
    vecs[4]  = '{1'b1, 8'h80, 1'b0, 4'h0, 1'b0, 1'b0, 3'd2, 1'b1, 1'b1, 1'b0, 8'h00, 8'd0, 1'b0};
    vecs[5]  = '{1'b0, 8'h00, 1'b0, 4'h0, 1'b0, 1'b0, 3'd2, 1'b1, 1'b0, 1'b0, 8'h00, 8'd0, 1'b0};
    vecs[6]  = '{1'b0, 8'h00, 1'b1, 4'h0, 1'b0, 1'b0, 3'd2, 1'b1, 1'b0, 1'b1, 8'h11, 8'd0, 1'b0};
    vecs[7]  = '{1'b0, 8'h00, 1'b1, 4'h1, 1'b0, 1'b0, 3'd2, 1'b1, 1'b0, 1'b1, 8'h22, 8'd0, 1'b0};
    vecs[8]  = '{1'b0, 8'h00, 1'b1, 4'h2, 1'b0, 1'b0, 3'd2, 1'b1, 1'b0, 1'b1, 8'h33, 8'd0, 1'b0};
    vecs[9]  = '{1'b0, 8'h00, 1'b0, 4'h0, 1'b0, 1'b0, 3'd2, 1'b1, 1'b0, 1'b0, 8'h33, 8'd0, 1'b0};
    vecs[10] = '{1'b0, 8'h00, 1'b0, 4'h0, 1'b1, 1'b0, 3'd2, 1'b1, 1'b0, 1'b0, 8'h33, 8'd1, 1'b0};
    vecs[11] = '{1'b1, 8'h00, 1'b0, 4'h0, 1'b1, 1'b1, 3'd4, 1'b1, 1'b0, 1'b0, 8'h33, 8'd2, 1'b0};
    vecs[12] = '{1'b0, 8'h00, 1'b1, 4'h0, 1'b1, 1'b0, 3'd4, 1'b1, 1'b0, 1'b0, 8'h33, 8'd2, 1'b0};
    vecs[13] = '{1'b1, 8'h00, 1'b0, 4'h0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 8'h33, 8'd2, 1'b0};
    vecs[14] = '{1'b1, 8'h55, 1'b0, 4'h0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 8'h33, 8'd2, 1'b1};
    vecs[15] = '{1'b1, 8'h40, 1'b0, 4'h0, 1'b0, 1'b0, 3'd1, 1'b1, 1'b0, 1'b0, 8'h33, 8'd2, 1'b1};
    vecs[16] = '{1'b1, 8'hAA, 1'b0, 4'h0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 8'h33, 8'd2, 1'b1};
    vecs[17] = '{1'b1, 8'h81, 1'b0, 4'h0, 1'b0, 1'b0, 3'd3, 1'b0, 1'b1, 1'b0, 8'h33, 8'd0, 1'b1};
    vecs[18] = '{1'b1, 8'h00, 1'b1, 4'h0, 1'b0, 1'b0, 3'd3, 1'b0, 1'b0, 1'b1, 8'hAA, 8'd0, 1'b1};
    vecs[19] = '{1'b0, 8'h00, 1'b1, 4'h0, 1'b0, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0, 8'hAA, 8'd0, 1'b1};
    vecs[20] = '{1'b0, 8'h00, 1'b0, 4'h0, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 8'hAA, 8'd1, 1'b1};

    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", 32'(status_state), 32'd0);
    check("rst_ready", 32'(host_ready), 32'd1);
    check("rst_start", 32'(core_start), 32'd0);
    check("rst_fvalid", 32'(core_fetch_valid), 32'd0);
    check("rst_fdata", 32'(core_fetch_data), 32'h00);
    check("rst_count", 32'(retire_count), 32'd0);
    check("rst_err", 32'(cmd_err), 32'd0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].hv, vecs[i].hd, vecs[i].req, vecs[i].addr, vecs[i].ret, vecs[i].hlt);
      tick();
      check($sformatf("v%0d_state", i), 32'(status_state), 32'(vecs[i].st));
      check($sformatf("v%0d_ready", i), 32'(host_ready), 32'(vecs[i].rdy));
      check($sformatf("v%0d_start", i), 32'(core_start), 32'(vecs[i].start));
      check($sformatf("v%0d_fvalid", i), 32'(core_fetch_valid), 32'(vecs[i].fv));
      check($sformatf("v%0d_fdata", i), 32'(core_fetch_data), 32'(vecs[i].fd));
      check($sformatf("v%0d_count", i), 32'(retire_count), 32'(vecs[i].cnt));
      check($sformatf("v%0d_err", i), 32'(cmd_err), 32'(vecs[i].err));
    end
    idle_inputs();
    tick();

    // Reset in the middle of a 16-byte load; memory must come back cleared.
    drive(1'b1, 8'h4F, 1'b0, 4'h0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 8'h77, 1'b0, 4'h0, 1'b0, 1'b0);
    tick();
    check("midload_state", 32'(status_state), 32'd1);
    idle_inputs();
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_state", 32'(status_state), 32'd0);
    check("async_rst_ready", 32'(host_ready), 32'd1);
    check("async_rst_err", 32'(cmd_err), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    drive(1'b1, 8'h80, 1'b0, 4'h0, 1'b0, 1'b0);
    tick();
    check("post_rst_run", 32'(status_state), 32'd2);
    drive(1'b0, 8'h00, 1'b1, 4'h0, 1'b0, 1'b0);
    tick();
    check("post_rst_fvalid", 32'(core_fetch_valid), 32'd1);
    check("post_rst_mem0", 32'(core_fetch_data), 32'h00);
    drive(1'b1, 8'h00, 1'b0, 4'h0, 1'b0, 1'b0);
    tick();
    check("post_rst_stop", 32'(status_state), 32'd0);

    // Retire counter wrap over 300 pulses, then a stop with a fetch in flight.
    drive(1'b1, 8'h80, 1'b0, 4'h0, 1'b0, 1'b0);
    tick();
    check("wrap_start", 32'(core_start), 32'd1);
    drive(1'b0, 8'h00, 1'b0, 4'h0, 1'b1, 1'b0);
    repeat (300) tick();
    idle_inputs();
    tick();
    check("wrap_count", 32'(retire_count), 32'd44);
    drive(1'b1, 8'h00, 1'b1, 4'h1, 1'b0, 1'b0);
    tick();
    check("wrap_stop_state", 32'(status_state), 32'd0);
    check("leave_run_fvalid", 32'(core_fetch_valid), 32'd1);
    drive(1'b0, 8'h00, 1'b0, 4'h0, 1'b1, 1'b0);
    tick();
    check("idle_retire_ignored", 32'(retire_count), 32'd44);

    // Halt during STEP, then restart RUN straight from HALTED.
    drive(1'b1, 8'h81, 1'b0, 4'h0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 8'h00, 1'b0, 4'h0, 1'b0, 1'b1);
    tick();
    check("step_halt_state", 32'(status_state), 32'd4);
    drive(1'b1, 8'h80, 1'b0, 4'h0, 1'b0, 1'b0);
    tick();
    check("halt_restart_state", 32'(status_state), 32'd2);
    check("halt_restart_start", 32'(core_start), 32'd1);
    check("halt_restart_count", 32'(retire_count), 32'd0);
    idle_inputs();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
